branch_resolve_unit: RTL and testbench

// Execute-end counterpart of the fetch-stage static jump/branch predictor.
// - Carries each fetch-time prediction (taken bit, target, PC+4) down through D and E.
// - Compares the prediction with the actual outcome resolved in E.
// - On a mismatch, issues one redirect PC and a multi-cycle front-end flush.
// - Keeps saturating resolved-branch and mispredict counters for performance readout.

---
 rtl/branch_resolve_unit.sv | 150 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// +----------------------------------------------------------------------------+
// | branch_resolve_unit: tracks fetch-time jump/branch predictions down to E,  |
// | redirects and flushes the front end on a mispredict, counts outcomes.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_resolve_unit #(
    parameter int AW           = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             is_ctrl_f,
    input  logic             take_jb_f,
    input  logic [AW-1:0]    jb_target_f,
    input  logic [AW-1:0]    pc_f,
    input  logic             resolve_e,
    input  logic             actual_taken_e,
    input  logic [AW-1:0]    actual_target_e,
    output logic             redirect,
    output logic [AW-1:0]    redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef struct packed {
        logic          valid;
        logic          pred_taken;
        logic [AW-1:0] pred_target;
        logic [AW-1:0] pc_plus4;
    } entry_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [FC_W-1:0] fcnt, fcnt_nxt;
    entry_t          ent_f, ent_d, ent_e, ent_d_nxt, ent_e_nxt;
    logic            resolve, mispredict, start_flush;

    always_comb begin
        ent_f.valid       = is_ctrl_f;
        ent_f.pred_taken  = take_jb_f;
        ent_f.pred_target = jb_target_f;
        ent_f.pc_plus4    = pc_f + AW'(4);
    end

    // Resolution is only honoured in IDLE; during FLUSH the E slot is wrong-path.
    assign resolve    = (state == S_IDLE) && ent_e.valid && resolve_e;
    assign mispredict = resolve &&
                        ((ent_e.pred_taken != actual_taken_e) ||
                         (actual_taken_e && (ent_e.pred_target != actual_target_e)));

    always_comb begin
        state_nxt   = state;
        fcnt_nxt    = fcnt;
        start_flush = 1'b0;
        case (state)
            S_IDLE: begin
                if (mispredict) begin
                    state_nxt   = S_FLUSH;
                    fcnt_nxt    = FC_W'(FLUSH_CYCLES - 1);
                    start_flush = 1'b1;
                end
            end
            S_FLUSH: begin
                if (fcnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    fcnt_nxt = fcnt - FC_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Entries behind a mispredict are wrong-path, so they are dropped at the same edge.
    always_comb begin
        ent_d_nxt = ent_d;
        ent_e_nxt = ent_e;
        if ((state == S_FLUSH) || mispredict) begin
            ent_d_nxt.valid = 1'b0;
            ent_e_nxt.valid = 1'b0;
        end else if (!stall) begin
            ent_e_nxt = ent_d;
            ent_d_nxt = ent_f;
        end else if (resolve) begin
            ent_e_nxt.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_d <= '0;
            ent_e <= '0;
        end else begin
            ent_d <= ent_d_nxt;
            ent_e <= ent_e_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= start_flush;
            if (start_flush) begin
                redirect_pc <= actual_taken_e ? actual_target_e : ent_e.pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

    assign flush = (state == S_FLUSH);

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// +----------------------------------------------------------------------------+
// | tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        is_ctrl_f = 1'b0;
    logic        take_jb_f = 1'b0;
    logic [31:0] jb_target_f = '0;
    logic [31:0] pc_f = '0;
    logic        resolve_e = 1'b0;
    logic        actual_taken_e = 1'b0;
    logic [31:0] actual_target_e = '0;

    logic        redirect, flush;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;

    logic        redirect4, flush4;
    logic [31:0] redirect_pc4;
    logic [3:0]  branch_count4, mispredict_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.AW(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .is_ctrl_f(is_ctrl_f),
        .take_jb_f(take_jb_f), .jb_target_f(jb_target_f), .pc_f(pc_f),
        .resolve_e(resolve_e), .actual_taken_e(actual_taken_e),
        .actual_target_e(actual_target_e), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    branch_resolve_unit #(.AW(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .is_ctrl_f(is_ctrl_f),
        .take_jb_f(take_jb_f), .jb_target_f(jb_target_f), .pc_f(pc_f),
        .resolve_e(resolve_e), .actual_taken_e(actual_taken_e),
        .actual_target_e(actual_target_e), .redirect(redirect4),
        .redirect_pc(redirect_pc4), .flush(flush4), .branch_count(branch_count4),
        .mispredict_count(mispredict_count4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; is_ctrl_f = 1'b0; take_jb_f = 1'b0;
        jb_target_f = '0; pc_f = '0; resolve_e = 1'b0;
        actual_taken_e = 1'b0; actual_target_e = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Presents a control instruction in F and advances it to E.
    task automatic push_f(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        is_ctrl_f = 1'b1; take_jb_f = tk; jb_target_f = tgt; pc_f = pc;
        step();
        is_ctrl_f = 1'b0;
        step();
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        resolve_e = 1'b1; actual_taken_e = tk; actual_target_e = tgt;
        step();
        resolve_e = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({redirect, flush, redirect_pc, branch_count, mispredict_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%0b fl=%0b pc=%h bc=%0d mc=%0d, want all 0",
                     redirect, flush, redirect_pc, branch_count, mispredict_count);
        end
    endtask

    task automatic test_correct_taken();
        do_reset();
        push_f(32'h100, 1'b1, 32'h80);
        resolve(1'b1, 32'h80);
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL correct_no_redirect: got rd=%0b fl=%0b, want 0/0", redirect, flush);
        end
        checks++;
        if (branch_count !== 16'd1 || mispredict_count !== 16'd0) begin
            errors++;
            $display("FAIL correct_counts: got %0d/%0d, want 1/0", branch_count, mispredict_count);
        end
        step();
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL correct_quiet_after: got rd=%0b fl=%0b, want 0/0", redirect, flush);
        end
    endtask

    task automatic test_mispredict_not_taken();
        do_reset();
        push_f(32'h100, 1'b1, 32'h80);
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL mp_nt_before: got rd=%0b fl=%0b, want 0/0", redirect, flush);
        end
        resolve(1'b0, 32'h0);
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h104 || flush !== 1'b1) begin
            errors++;
            $display("FAIL mp_nt_redirect: got rd=%0b pc=%h fl=%0b, want 1/00000104/1",
                     redirect, redirect_pc, flush);
        end
        step();
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b1) begin
            errors++;
            $display("FAIL mp_nt_flush2: got rd=%0b fl=%0b, want 0/1", redirect, flush);
        end
        step();
        checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'h104) begin
            errors++;
            $display("FAIL mp_nt_flush_end: got fl=%0b pc=%h, want 0/00000104", flush, redirect_pc);
        end
        checks++;
        if (branch_count !== 16'd1 || mispredict_count !== 16'd1) begin
            errors++;
            $display("FAIL mp_nt_counts: got %0d/%0d, want 1/1", branch_count, mispredict_count);
        end
    endtask

    task automatic test_mispredict_taken();
        do_reset();
        push_f(32'h200, 1'b0, 32'h240);
        resolve(1'b1, 32'h240);
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h240) begin
            errors++;
            $display("FAIL mp_tk_redirect: got rd=%0b pc=%h, want 1/00000240", redirect, redirect_pc);
        end
        checks++;
        if (branch_count !== 16'd1 || mispredict_count !== 16'd1) begin
            errors++;
            $display("FAIL mp_tk_counts: got %0d/%0d, want 1/1", branch_count, mispredict_count);
        end
        step();
        step();
    endtask

    task automatic test_jalr_stall_flush();
        do_reset();
        push_f(32'h300, 1'b0, 32'h0);
        resolve(1'b1, 32'h1000);
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h1000 || flush !== 1'b1) begin
            errors++;
            $display("FAIL jalr_redirect: got rd=%0b pc=%h fl=%0b, want 1/00001000/1",
                     redirect, redirect_pc, flush);
        end
        // Stall, new F instruction and a stray resolve all land inside FLUSH.
        stall = 1'b1; is_ctrl_f = 1'b1; take_jb_f = 1'b1; jb_target_f = 32'h40; pc_f = 32'h304;
        resolve_e = 1'b1; actual_taken_e = 1'b0; actual_target_e = 32'h0;
        step();
        checks++;
        if (flush !== 1'b1 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL jalr_flush_cyc2: got fl=%0b rd=%0b, want 1/0", flush, redirect);
        end
        step();
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL jalr_flush_done: got fl=%0b, want 0", flush);
        end
        stall = 1'b0; is_ctrl_f = 1'b0;
        step();
        step();
        resolve_e = 1'b0;
        checks++;
        if (branch_count !== 16'd1 || mispredict_count !== 16'd1 || redirect !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL jalr_entries_invalid: got bc=%0d mc=%0d rd=%0b fl=%0b, want 1/1/0/0",
                     branch_count, mispredict_count, redirect, flush);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        is_ctrl_f = 1'b1; take_jb_f = 1'b1; jb_target_f = 32'h80; pc_f = 32'h600;
        step();
        pc_f = 32'h700;
        step();
        is_ctrl_f = 1'b0;
        resolve(1'b0, 32'h0);
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h604) begin
            errors++;
            $display("FAIL b2b_first: got rd=%0b pc=%h, want 1/00000604", redirect, redirect_pc);
        end
        step();
        step();
        resolve_e = 1'b1; actual_taken_e = 1'b0;
        step();
        step();
        resolve_e = 1'b0;
        checks++;
        if (redirect !== 1'b0 || branch_count !== 16'd1 || mispredict_count !== 16'd1) begin
            errors++;
            $display("FAIL b2b_second_flushed: got rd=%0b bc=%0d mc=%0d, want 0/1/1",
                     redirect, branch_count, mispredict_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push_f(32'h400, 1'b1, 32'h80);
            resolve(1'b0, 32'h0);
            step();
            step();
        end
        checks++;
        if (branch_count4 !== 4'd15 || mispredict_count4 !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt4: got %0d/%0d, want 15/15", branch_count4, mispredict_count4);
        end
        checks++;
        if (branch_count !== 16'd20 || mispredict_count !== 16'd20) begin
            errors++;
            $display("FAIL sat_cnt16: got %0d/%0d, want 20/20", branch_count, mispredict_count);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        push_f(32'h100, 1'b1, 32'h80);
        resolve(1'b0, 32'h0);
        checks++;
        if (flush !== 1'b1 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got fl=%0b rd=%0b, want 1/1", flush, redirect);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (flush !== 1'b0 || redirect !== 1'b0 || branch_count !== 16'd0 ||
            mispredict_count !== 16'd0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: got fl=%0b rd=%0b bc=%0d mc=%0d pc=%h, want all 0",
                     flush, redirect, branch_count, mispredict_count, redirect_pc);
        end
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_pulse: got rd=%0b fl=%0b, want 0/0", redirect, flush);
        end
        push_f(32'h500, 1'b0, 32'h0);
        resolve(1'b0, 32'h999);
        checks++;
        if (redirect !== 1'b0 || flush !== 1'b0 || branch_count !== 16'd1 || mispredict_count !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_after_correct: got rd=%0b fl=%0b bc=%0d mc=%0d, want 0/0/1/0",
                     redirect, flush, branch_count, mispredict_count);
        end
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_mispredict_not_taken();
        test_mispredict_taken();
        test_jalr_stall_flush();
        test_back_to_back();
        test_saturation();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
